ieee_to_fixed: RTL and testbench

IEEE_TO_FIXED -- requirements
Module: ieee_to_fixed

---
 rtl/ieee_to_fixed_pkg.sv | 32 +++
 rtl/fixed_round_sat.sv | 61 ++++++
 rtl/ieee_to_fixed.sv | 177 +++++++++++++++++
 tb/tb_ieee_to_fixed.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ieee_to_fixed_pkg.sv
// Shared IEEE-754 single-precision field constants and operand classes
// for the float-to-fixed converter.
package ieee_to_fixed_pkg;

   localparam int IEEE_BIAS = 127;
   localparam int EXP_W     = 8;
   localparam int MAN_W     = 23;
   localparam int SIG_W     = MAN_W + 1;     // significand with hidden bit
   localparam int K_W       = 11;            // signed shift amount, covers -149..+167

   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } cls_e;

   // Denormals are grouped with zero: they are flushed, never converted.
   function automatic cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      cls_e c;
      if (e == '0)
         c = CLS_ZERO;
      else if (e == EXP_ONES)
         c = (m == '0) ? CLS_INF : CLS_NAN;
      else
         c = CLS_NORM;
      return c;
   endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Final-stage arithmetic: rounds the aligned magnitude, negates it and
// saturates to the signed OUT_W range. Purely combinational.
module fixed_round_sat
   import ieee_to_fixed_pkg::*;
#(
   parameter int OUT_W = 32,
   parameter int ROUND = 0
) (
   input  logic             sign_i,
   input  cls_e             cls_i,
   input  logic [OUT_W-1:0] mag_i,
   input  logic             guard_i,
   input  logic             sticky_i,
   input  logic             big_i,
   output logic [OUT_W-1:0] data_o,
   output logic             ovf_o,
   output logic             nan_o
);

   // Largest representable magnitudes per sign, one bit wider than the
   // output so a rounding carry-out is still visible to the compare.
   localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   logic             round_up;
   logic [OUT_W:0]   mag_r;
   logic [OUT_W-1:0] mag_lo;
   logic             too_big;

   // Ties-to-even on the magnitude, so rounding is symmetric about zero.
   assign round_up = (ROUND != 0) && guard_i && (sticky_i || mag_i[0]);
   assign mag_r    = {1'b0, mag_i} + {{OUT_W{1'b0}}, round_up};
   assign mag_lo   = mag_r[OUT_W-1:0];
   assign too_big  = big_i || (sign_i ? (mag_r > NEG_LIM) : (mag_r > POS_LIM));

   // Select the result by operand class; only normal numbers go through rounding.
   always_comb begin
      data_o = '0;
      ovf_o  = 1'b0;
      nan_o  = 1'b0;
      case (cls_i)
         CLS_NAN: nan_o = 1'b1;
         CLS_INF: begin
            ovf_o  = 1'b1;
            data_o = sign_i ? SAT_NEG : SAT_POS;
         end
         CLS_NORM: begin
            if (too_big) begin
               ovf_o  = 1'b1;
               data_o = sign_i ? SAT_NEG : SAT_POS;
            end else begin
               data_o = sign_i ? -mag_lo : mag_lo;
            end
         end
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/ieee_to_fixed.sv
// IEEE-754 single to signed fixed-point converter. Three-stage pipeline
// (unpack, align, round/saturate) with valid/ready flow control on both
// sides; stages advance whenever the stage ahead is empty or draining.
module ieee_to_fixed
   import ieee_to_fixed_pkg::*;
#(
   parameter int OUT_W     = 32,
   parameter int FRAC_BITS = 16,
   parameter int ROUND     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_ovf,
   output logic             out_nan
);

   localparam int RSH_MAX = SIG_W + 1;          // beyond this every bit is sticky
   localparam int EXT_W   = SIG_W + RSH_MAX;

   localparam logic signed [K_W-1:0] K_OFF   = K_W'(IEEE_BIAS + MAN_W);
   localparam logic signed [K_W-1:0] K_FRAC  = K_W'(FRAC_BITS);
   localparam logic signed [K_W-1:0] K_MAX   = K_W'(OUT_W - SIG_W);
   localparam logic signed [K_W-1:0] RSH_CAP = K_W'(RSH_MAX);

   // ---------------- pipeline control ----------------
   logic s1_valid_q, s2_valid_q, s3_valid_q;
   logic s1_valid_d, s2_valid_d, s3_valid_d;
   logic load1, load2, load3;

   assign load3    = s2_valid_q & (~s3_valid_q | out_ready);
   assign load2    = s1_valid_q & (~s2_valid_q | load3);
   assign in_ready = rst & (~s1_valid_q | load2);
   assign load1    = in_valid & in_ready;

   assign s1_valid_d = load1 | (s1_valid_q & ~load2);
   assign s2_valid_d = load2 | (s2_valid_q & ~load3);
   assign s3_valid_d = load3 | (s3_valid_q & ~out_ready);

   // Stage-valid bits; reset empties the pipe so in-flight words vanish.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s3_valid_q <= s3_valid_d;
      end
   end

   // ---------------- S1: unpack / classify ----------------
   logic [EXP_W-1:0]        exp_w;
   logic [MAN_W-1:0]        man_w;
   logic signed [K_W-1:0]   exp_s;
   cls_e                    s1_cls_d, s1_cls_q;
   logic [SIG_W-1:0]        s1_sig_d, s1_sig_q;
   logic signed [K_W-1:0]   s1_k_d, s1_k_q;
   logic                    s1_sign_q;

   assign exp_w    = in_data[30:23];
   assign man_w    = in_data[22:0];
   assign exp_s    = {3'b000, exp_w};
   assign s1_cls_d = classify(exp_w, man_w);
   assign s1_sig_d = {(s1_cls_d == CLS_NORM), man_w};
   // k = e - 150 + FRAC_BITS: how far the 24-bit significand must move left.
   assign s1_k_d   = exp_s - K_OFF + K_FRAC;

   // Capture the unpacked operand when a word is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_sign_q <= 1'b0;
         s1_cls_q  <= CLS_ZERO;
         s1_sig_q  <= '0;
         s1_k_q    <= '0;
      end else if (load1) begin
         s1_sign_q <= in_data[31];
         s1_cls_q  <= s1_cls_d;
         s1_sig_q  <= s1_sig_d;
         s1_k_q    <= s1_k_d;
      end
   end

   // ---------------- S2: align shift ----------------
   logic                    s2_sign_q, s2_guard_q, s2_sticky_q, s2_big_q;
   logic                    s2_guard_d, s2_sticky_d, s2_big_d;
   cls_e                    s2_cls_q;
   logic [OUT_W-1:0]        s2_mag_d, s2_mag_q;
   logic signed [K_W-1:0]   neg_k;
   logic [4:0]              rsh;
   logic [EXT_W-1:0]        ext;

   assign neg_k = -s1_k_q;

   // Shift the significand into place; right shifts keep guard and sticky.
   // Any k above K_MAX puts the leading one at or past the sign bit.
   always_comb begin
      s2_guard_d  = 1'b0;
      s2_sticky_d = 1'b0;
      s2_mag_d    = '0;
      rsh         = '0;
      ext         = '0;
      s2_big_d    = (s1_cls_q == CLS_NORM) && (s1_k_q > K_MAX);
      if (s1_k_q >= 0) begin
         s2_mag_d = OUT_W'(s1_sig_q) << s1_k_q[7:0];
      end else begin
         rsh         = (neg_k > RSH_CAP) ? 5'(RSH_MAX) : neg_k[4:0];
         ext         = {s1_sig_q, {RSH_MAX{1'b0}}} >> rsh;
         s2_mag_d    = OUT_W'(ext[EXT_W-1 -: SIG_W]);
         s2_guard_d  = ext[RSH_MAX-1];
         s2_sticky_d = |ext[RSH_MAX-2:0];
      end
   end

   // Capture the aligned magnitude when S1 moves forward.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_sign_q   <= 1'b0;
         s2_cls_q    <= CLS_ZERO;
         s2_mag_q    <= '0;
         s2_guard_q  <= 1'b0;
         s2_sticky_q <= 1'b0;
         s2_big_q    <= 1'b0;
      end else if (load2) begin
         s2_sign_q   <= s1_sign_q;
         s2_cls_q    <= s1_cls_q;
         s2_mag_q    <= s2_mag_d;
         s2_guard_q  <= s2_guard_d;
         s2_sticky_q <= s2_sticky_d;
         s2_big_q    <= s2_big_d;
      end
   end

   // ---------------- S3: round / negate / saturate ----------------
   logic [OUT_W-1:0] s3_data_d, s3_data_q;
   logic             s3_ovf_d, s3_ovf_q, s3_nan_d, s3_nan_q;

   fixed_round_sat #(
      .OUT_W (OUT_W),
      .ROUND (ROUND)
   ) u_round_sat (
      .sign_i   (s2_sign_q),
      .cls_i    (s2_cls_q),
      .mag_i    (s2_mag_q),
      .guard_i  (s2_guard_q),
      .sticky_i (s2_sticky_q),
      .big_i    (s2_big_q),
      .data_o   (s3_data_d),
      .ovf_o    (s3_ovf_d),
      .nan_o    (s3_nan_d)
   );

   // Output registers only load on advance, so they hold steady under stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s3_data_q <= '0;
         s3_ovf_q  <= 1'b0;
         s3_nan_q  <= 1'b0;
      end else if (load3) begin
         s3_data_q <= s3_data_d;
         s3_ovf_q  <= s3_ovf_d;
         s3_nan_q  <= s3_nan_d;
      end
   end

   assign out_valid = s3_valid_q;
   assign out_data  = s3_data_q;
   assign out_ovf   = s3_ovf_q;
   assign out_nan   = s3_nan_q;

endmodule

// File: tb/tb_ieee_to_fixed.sv
// Bench for ieee_to_fixed: two instances (truncate and round-to-nearest)
// share stimulus and handshake; results are checked against a real-number
// reference model.
module tb_ieee_to_fixed;

   localparam int OUT_W     = 32;
   localparam int FRAC_BITS = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready0, in_ready1;
   logic        out_valid0, out_valid1;
   logic [31:0] out_data0, out_data1;
   logic        out_ovf0, out_ovf1, out_nan0, out_nan1;

   always #5 clk = ~clk;

   ieee_to_fixed #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .ROUND(0)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
      .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_ovf(out_ovf0), .out_nan(out_nan0));

   ieee_to_fixed #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .ROUND(1)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
      .out_ovf(out_ovf1), .out_nan(out_nan1));

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] acc_q[$];
   logic [33:0] res0_q[$];
   logic [33:0] res1_q[$];

   // Reference: real value scaled by 2^FRAC_BITS, then truncate or round
   // half-to-even on the magnitude, then clamp. Returns {nan, ovf, data}.
   function automatic logic [33:0] model(input logic [31:0] x, input bit rnd);
      logic        s;
      int          e, m;
      real         mag, fl, fr;
      logic [31:0] d;
      s = x[31];
      e = int'(x[30:23]);
      m = int'(x[22:0]);
      if (e == 255)
         return (m != 0) ? {2'b10, 32'h0} : {2'b01, (s ? 32'h80000000 : 32'h7FFFFFFF)};
      if (e == 0)
         return 34'h0;
      mag = (1.0 + real'(m) / 8388608.0) * (2.0 ** (e - 127 + FRAC_BITS));
      fl  = $floor(mag);
      fr  = mag - fl;
      if (rnd && (fr > 0.5 || (fr == 0.5 && $floor(fl / 2.0) * 2.0 != fl)))
         fl = fl + 1.0;
      if (!s) begin
         if (fl > 2147483647.0) return {2'b01, 32'h7FFFFFFF};
         d = 32'(longint'(fl));
      end else begin
         if (fl > 2147483648.0) return {2'b01, 32'h80000000};
         d = 32'(-longint'(fl));
      end
      return {2'b00, d};
   endfunction

   function automatic logic [31:0] rand_word(input int e_lo, input int e_hi);
      logic [31:0] w;
      w[31]    = 1'($urandom_range(0, 1));
      w[30:23] = 8'($urandom_range(e_lo, e_hi));
      w[22:0]  = 23'($urandom);
      return w;
   endfunction

   // One clock of stimulus: drive on the falling edge, observe 1 time unit
   // later, record accepted inputs and delivered results.
   task automatic cycle(input logic v, input logic [31:0] d, input logic ordy, output logic took);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      out_ready = ordy;
      #1;
      took = v & in_ready0;
      if (took) acc_q.push_back(d);
      if (out_valid0 && ordy) begin
         res0_q.push_back({out_nan0, out_ovf0, out_data0});
         res1_q.push_back({out_nan1, out_ovf1, out_data1});
      end
   endtask

   task automatic clear_queues();
      acc_q.delete();
      res0_q.delete();
      res1_q.delete();
   endtask

   task automatic drain();
      logic took;
      for (int i = 0; i < 60 && res0_q.size() < acc_q.size(); i++)
         cycle(1'b0, 32'h0, 1'b1, took);
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h3F800000; out_ready = 1'b1;
      #1;
      n_cmp++;
      if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
         n_bad++; $display("FAIL reset_out_valid: got %b/%b expected 0", out_valid0, out_valid1);
      end
      n_cmp++;
      if ({out_nan0, out_ovf0, out_data0} !== 34'h0) begin
         n_bad++; $display("FAIL reset_out_data: got %h expected 0", {out_nan0, out_ovf0, out_data0});
      end
      n_cmp++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
         n_bad++; $display("FAIL reset_in_ready: got %b/%b expected 0", in_ready0, in_ready1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (in_ready0 !== 1'b1) begin
         n_bad++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready0);
      end
      $display("reset: outputs idle during reset, in_ready=%b after release", in_ready0);
   endtask

   logic [31:0] dir_in [14] = '{
      32'h3F800000, 32'hC0200000, 32'h47000000, 32'hC7000000, 32'h7F800000,
      32'h7FC00000, 32'h37C00000, 32'h38200000, 32'h00400000, 32'hFF800000,
      32'h3F7FFFFF, 32'hC7000080, 32'hB7000000, 32'hB7C00000};
   logic [33:0] dir_e0 [14] = '{
      {2'b00, 32'h00010000}, {2'b00, 32'hFFFD8000}, {2'b01, 32'h7FFFFFFF}, {2'b00, 32'h80000000},
      {2'b01, 32'h7FFFFFFF}, {2'b10, 32'h00000000}, {2'b00, 32'h00000001}, {2'b00, 32'h00000002},
      {2'b00, 32'h00000000}, {2'b01, 32'h80000000}, {2'b00, 32'h0000FFFF}, {2'b01, 32'h80000000},
      {2'b00, 32'h00000000}, {2'b00, 32'hFFFFFFFF}};
   logic [33:0] dir_e1 [14] = '{
      {2'b00, 32'h00010000}, {2'b00, 32'hFFFD8000}, {2'b01, 32'h7FFFFFFF}, {2'b00, 32'h80000000},
      {2'b01, 32'h7FFFFFFF}, {2'b10, 32'h00000000}, {2'b00, 32'h00000002}, {2'b00, 32'h00000002},
      {2'b00, 32'h00000000}, {2'b01, 32'h80000000}, {2'b00, 32'h00010000}, {2'b01, 32'h80000000},
      {2'b00, 32'h00000000}, {2'b00, 32'hFFFFFFFE}};

   task automatic test_directed();
      logic took;
      int   idx;
      clear_queues();
      idx = 0;
      for (int c = 0; c < 40 && idx < 14; c++) begin
         cycle(1'b1, dir_in[idx], 1'b1, took);
         if (took) idx++;
      end
      drain();
      n_cmp++;
      if (res0_q.size() != 14) begin
         n_bad++; $display("FAIL directed_count: got %0d expected 14", res0_q.size());
      end
      for (int i = 0; i < 14 && i < res0_q.size(); i++) begin
         n_cmp++;
         if (res0_q[i] !== dir_e0[i]) begin
            n_bad++; $display("FAIL directed_trunc[%0d] in=%h: got %h expected %h", i, dir_in[i], res0_q[i], dir_e0[i]);
         end
         n_cmp++;
         if (res1_q[i] !== dir_e1[i]) begin
            n_bad++; $display("FAIL directed_round[%0d] in=%h: got %h expected %h", i, dir_in[i], res1_q[i], dir_e1[i]);
         end
         $display("directed %0d: in=%h trunc=%h round=%h", i, dir_in[i], res0_q[i], res1_q[i]);
      end
   endtask

   task automatic test_random();
      localparam int N = 300;
      logic [31:0] words[N];
      logic        took;
      int          idx, r;
      clear_queues();
      for (int i = 0; i < N; i++) begin
         r = $urandom_range(0, 99);
         if (r < 6)       words[i] = rand_word(255, 255);
         else if (r < 9)  words[i] = {1'($urandom_range(0, 1)), 8'hFF, 23'h0};
         else if (r < 14) words[i] = rand_word(0, 0);
         else             words[i] = rand_word(95, 150);
      end
      idx = 0;
      for (int c = 0; c < 5000 && idx < N; c++) begin
         cycle((idx < N) && ($urandom_range(0, 99) < 75), words[idx < N ? idx : 0],
               $urandom_range(0, 99) < 70, took);
         if (took) idx++;
      end
      drain();
      n_cmp++;
      if (res0_q.size() != N || acc_q.size() != N) begin
         n_bad++; $display("FAIL random_count: got %0d/%0d expected %0d", res0_q.size(), acc_q.size(), N);
      end
      for (int i = 0; i < N && i < res0_q.size() && i < acc_q.size(); i++) begin
         n_cmp++;
         if (res0_q[i] !== model(acc_q[i], 1'b0)) begin
            n_bad++; $display("FAIL random_trunc[%0d] in=%h: got %h expected %h", i, acc_q[i], res0_q[i], model(acc_q[i], 1'b0));
         end
         n_cmp++;
         if (res1_q[i] !== model(acc_q[i], 1'b1)) begin
            n_bad++; $display("FAIL random_round[%0d] in=%h: got %h expected %h", i, acc_q[i], res1_q[i], model(acc_q[i], 1'b1));
         end
         $display("random %0d: in=%h trunc=%h round=%h", i, acc_q[i], res0_q[i], res1_q[i]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words[8];
      logic [31:0] hold;
      logic        took, stall;
      int          idx;
      clear_queues();
      for (int i = 0; i < 8; i++) words[i] = rand_word(110, 145);
      idx  = 0;
      hold = '0;
      for (int c = 0; c < 60 && (idx < 8 || res0_q.size() < 8); c++) begin
         stall = (c >= 4 && c < 8);
         cycle(idx < 8, words[idx < 8 ? idx : 0], !stall, took);
         if (took) idx++;
         if (stall) begin
            n_cmp++;
            if (in_ready0 !== 1'b0) begin
               n_bad++; $display("FAIL b2b_in_ready_stall c=%0d: got %b expected 0", c, in_ready0);
            end
            n_cmp++;
            if (out_valid0 !== 1'b1) begin
               n_bad++; $display("FAIL b2b_out_valid_stall c=%0d: got %b expected 1", c, out_valid0);
            end
            if (c == 4) hold = out_data0;
            else begin
               n_cmp++;
               if (out_data0 !== hold) begin
                  n_bad++; $display("FAIL b2b_hold c=%0d: got %h expected %h", c, out_data0, hold);
               end
            end
         end
      end
      n_cmp++;
      if (res0_q.size() != 8) begin
         n_bad++; $display("FAIL b2b_count: got %0d expected 8", res0_q.size());
      end
      for (int i = 0; i < 8 && i < res0_q.size(); i++) begin
         n_cmp++;
         if (res0_q[i] !== model(words[i], 1'b0) || res1_q[i] !== model(words[i], 1'b1)) begin
            n_bad++; $display("FAIL b2b_order[%0d] in=%h: got %h/%h expected %h/%h", i, words[i],
                              res0_q[i], res1_q[i], model(words[i], 1'b0), model(words[i], 1'b1));
         end
         $display("b2b %0d: in=%h trunc=%h round=%h", i, words[i], res0_q[i], res1_q[i]);
      end
   endtask

   task automatic test_reset_midflight();
      logic        took;
      logic [31:0] w;
      int          n;
      clear_queues();
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_word(120, 140), 1'b0, took);
      n_cmp++;
      if (acc_q.size() != 3) begin
         n_bad++; $display("FAIL midflight_fill: got %0d expected 3", acc_q.size());
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
         n_bad++; $display("FAIL midflight_reset: got valid=%b ready=%b expected 0/0", out_valid0, in_ready0);
      end
      @(negedge clk);
      rst = 1'b1;
      clear_queues();
      for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, took);
      n_cmp++;
      if (res0_q.size() != 0) begin
         n_bad++; $display("FAIL midflight_stale: got %0d results expected 0", res0_q.size());
      end
      w = rand_word(120, 140);
      cycle(1'b1, w, 1'b1, took);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 32'h0, 1'b1, took);
         n++;
         if (out_valid0) break;
      end
      n_cmp++;
      if (n != 3 || res0_q.size() != 1) begin
         n_bad++; $display("FAIL midflight_latency: got %0d cycles/%0d results expected 3/1", n, res0_q.size());
      end
      n_cmp++;
      if (res0_q.size() < 1 || res0_q[0] !== model(w, 1'b0) || res1_q[0] !== model(w, 1'b1)) begin
         n_bad++; $display("FAIL midflight_result in=%h: got %h expected %h", w,
                           (res0_q.size() > 0) ? res0_q[0] : 34'h0, model(w, 1'b0));
      end
      $display("midflight: in=%h latency=%0d", w, n);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
